// File: rtl/mulmod_barrett_pipe.sv
// Pipelined modular multiplier / multiply-accumulate, S = (A*B [+ C]) mod N, with a runtime
// modulus reduced by Barrett's method and a single global stall enable for back-pressure.
`timescale 1ns/1ps
module mulmod_barrett_pipe #(
  parameter int P_WIDTH    = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int MUL_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P_WIDTH-1:0]   A_in,
  input  logic [P_WIDTH-1:0]   B_in,
  input  logic [P_WIDTH-1:0]   C_in,
  input  logic [P_WIDTH-1:0]   N_in,
  input  logic [P_WIDTH:0]     Mu_in,
  input  logic                 mode_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   S_out,
  output logic [TAG_WIDTH-1:0] tag_out
);

  localparam int W  = P_WIDTH;
  localparam int ML = MUL_STAGES - 1;

  logic                 en_s;
  logic [2*W-1:0]       prod_s;

  // multiplier stage(s): product plus the per-beat sideband carried alongside
  logic [2*W-1:0]       m_x_r     [MUL_STAGES];
  logic [W-1:0]         m_n_r     [MUL_STAGES];
  logic [W:0]           m_mu_r    [MUL_STAGES];
  logic [W-1:0]         m_c_r     [MUL_STAGES];
  logic                 m_mode_r  [MUL_STAGES];
  logic [TAG_WIDTH-1:0] m_tag_r   [MUL_STAGES];
  logic                 m_valid_r [MUL_STAGES];

  // quotient estimate stage
  logic                 q_valid_r;
  logic [W:0]           q_q_r;
  logic [W+1:0]         q_xlo_r;
  logic [W-1:0]         q_n_r;
  logic [W-1:0]         q_c_r;
  logic                 q_mode_r;
  logic [TAG_WIDTH-1:0] q_tag_r;

  // partial remainder stage
  logic                 r_valid_r;
  logic [W+1:0]         r_rem_r;
  logic [W-1:0]         r_n_r;
  logic [W-1:0]         r_c_r;
  logic                 r_mode_r;
  logic [TAG_WIDTH-1:0] r_tag_r;

  logic [W:0]           q1_s;
  logic [2*W+1:0]       qmu_s;
  logic [W:0]           q_s;
  logic [2*W:0]         qn_s;
  logic [W+1:0]         rem_s;
  logic [W+1:0]         n_ext_s;
  logic [W+1:0]         r1_s;
  logic [W+1:0]         r2_s;
  logic [W:0]           s2_s;
  logic [W:0]           sum_s;
  logic [W-1:0]         res_s;
  logic                 unused_s;

  // No bubble collapse: every stage advances together or not at all.
  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;

  assign prod_s = {{W{1'b0}}, A_in} * {{W{1'b0}}, B_in};

  // x < 2^(2W) so q1 fits W+1 bits; the true quotient exceeds q by at most 2,
  // which is why only the low W+2 bits of x - q*N are needed.
  assign q1_s  = m_x_r[ML][2*W-1:W-1];
  assign qmu_s = {{(W+1){1'b0}}, q1_s} * {{(W+1){1'b0}}, m_mu_r[ML]};
  assign q_s   = qmu_s[2*W+1:W+1];
  assign qn_s  = {{W{1'b0}}, q_q_r} * {{(W+1){1'b0}}, q_n_r};
  assign rem_s = q_xlo_r - qn_s[W+1:0];

  assign unused_s = ^{qmu_s[W:0], qn_s[2*W:W+2], r2_s[W+1:W], sum_s[W]};

  // Final correction of r < 3N down to [0,N), then optional modular add of c.
  always_comb begin
    n_ext_s = {2'b00, r_n_r};
    r1_s    = r_rem_r;
    r2_s    = r_rem_r;
    s2_s    = '0;
    sum_s   = '0;
    res_s   = '0;
    if (r_rem_r >= n_ext_s) begin
      r1_s = r_rem_r - n_ext_s;
    end else begin
      r1_s = r_rem_r;
    end
    if (r1_s >= n_ext_s) begin
      r2_s = r1_s - n_ext_s;
    end else begin
      r2_s = r1_s;
    end
    s2_s = {1'b0, r2_s[W-1:0]} + {1'b0, r_c_r};
    if (s2_s >= {1'b0, r_n_r}) begin
      sum_s = s2_s - {1'b0, r_n_r};
    end else begin
      sum_s = s2_s;
    end
    if (r_mode_r) begin
      res_s = sum_s[W-1:0];
    end else begin
      res_s = r2_s[W-1:0];
    end
  end

  // Stage valid bits and the output register; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        m_valid_r[i] <= 1'b0;
      end
      q_valid_r <= 1'b0;
      r_valid_r <= 1'b0;
      out_valid <= 1'b0;
      S_out     <= '0;
      tag_out   <= '0;
    end else if (en_s) begin
      m_valid_r[0] <= in_valid;
      for (int i = 1; i < MUL_STAGES; i++) begin
        m_valid_r[i] <= m_valid_r[i-1];
      end
      q_valid_r <= m_valid_r[ML];
      r_valid_r <= q_valid_r;
      out_valid <= r_valid_r;
      if (r_valid_r) begin
        S_out   <= res_s;
        tag_out <= r_tag_r;
      end else begin
        S_out   <= S_out;
        tag_out <= tag_out;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Datapath registers; their contents only matter where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (en_s) begin
      m_x_r[0]    <= prod_s;
      m_n_r[0]    <= N_in;
      m_mu_r[0]   <= Mu_in;
      m_c_r[0]    <= C_in;
      m_mode_r[0] <= mode_in;
      m_tag_r[0]  <= tag_in;
      for (int i = 1; i < MUL_STAGES; i++) begin
        m_x_r[i]    <= m_x_r[i-1];
        m_n_r[i]    <= m_n_r[i-1];
        m_mu_r[i]   <= m_mu_r[i-1];
        m_c_r[i]    <= m_c_r[i-1];
        m_mode_r[i] <= m_mode_r[i-1];
        m_tag_r[i]  <= m_tag_r[i-1];
      end
      q_q_r    <= q_s;
      q_xlo_r  <= m_x_r[ML][W+1:0];
      q_n_r    <= m_n_r[ML];
      q_c_r    <= m_c_r[ML];
      q_mode_r <= m_mode_r[ML];
      q_tag_r  <= m_tag_r[ML];
      r_rem_r  <= rem_s;
      r_n_r    <= q_n_r;
      r_c_r    <= q_c_r;
      r_mode_r <= q_mode_r;
      r_tag_r  <= q_tag_r;
    end
  end

endmodule

// File: tb/tb_mulmod_barrett_pipe.sv
// Directed bench for mulmod_barrett_pipe: a W=16 instance for hand-computed vectors and
// handshake scenarios, plus a W=64 instance streaming against a wide-integer reference.
`timescale 1ns/1ps
module tb_mulmod_barrett_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, mode_in;
  logic [15:0] A_in, B_in, C_in, N_in, S_out;
  logic [16:0] Mu_in;
  logic [7:0]  tag_in, tag_out;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, mode64;
  logic [63:0] a64, b64, c64, n64, s64;
  logic [64:0] mu64;
  logic [7:0]  tag64, tag_out64;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] N1  = 16'd65521;
  localparam logic [16:0] MU1 = 17'd65551;

  mulmod_barrett_pipe #(.P_WIDTH(16), .TAG_WIDTH(8), .MUL_STAGES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_in(A_in), .B_in(B_in), .C_in(C_in), .N_in(N_in), .Mu_in(Mu_in),
    .mode_in(mode_in), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .S_out(S_out), .tag_out(tag_out)
  );

  mulmod_barrett_pipe #(.P_WIDTH(64), .TAG_WIDTH(8), .MUL_STAGES(3)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .A_in(a64), .B_in(b64), .C_in(c64), .N_in(n64), .Mu_in(mu64),
    .mode_in(mode64), .tag_in(tag64), .out_valid(out_valid64), .out_ready(out_ready64),
    .S_out(s64), .tag_out(tag_out64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one beat with out_ready held high and waits (bounded) for its result.
  task automatic do_beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] n, input logic [16:0] mu, input logic mode,
                         input logic [7:0] tag, output logic [15:0] s, output logic [7:0] t,
                         output int lat);
    A_in = a; B_in = b; C_in = c; N_in = n; Mu_in = mu; mode_in = mode; tag_in = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    s = 16'd0; t = 8'd0; lat = -1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (out_valid) begin
        lat = i; s = S_out; t = tag_out;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (S_out !== 16'd0) begin errors++; $display("FAIL reset_S_out got=%0d want=0", S_out); end
    checks++; if (tag_out !== 8'd0) begin errors++; $display("FAIL reset_tag_out got=%h want=00", tag_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_mul_mac();
    logic [15:0] va [6] = '{16'd65520, 16'd12345, 16'd65520, 16'd0,     16'd2, 16'd65520};
    logic [15:0] vb [6] = '{16'd65520, 16'd2,     16'd1,     16'd0,     16'd3, 16'd1};
    logic [15:0] vc [6] = '{16'd0,     16'd0,     16'd5,     16'd65520, 16'd7, 16'd1};
    logic        vm [6] = '{1'b0,      1'b0,      1'b1,      1'b1,      1'b0,  1'b1};
    logic [7:0]  vt [6] = '{8'h3C,     8'h11,     8'h22,     8'h33,     8'h44, 8'h55};
    // (-1)(-1)=1; 24690; 65520+5-N=4; 65520; c ignored in MUL so 6; 65520+1 wraps to 0
    logic [15:0] ve [6] = '{16'd1,     16'd24690, 16'd4,     16'd65520, 16'd6, 16'd0};
    logic [15:0] s;
    logic [7:0]  t;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      do_beat(va[i], vb[i], vc[i], N1, MU1, vm[i], vt[i], s, t, lat);
      checks++; if (s !== ve[i]) begin errors++; $display("FAIL mul_mac_S[%0d] got=%0d want=%0d", i, s, ve[i]); end
      checks++; if (t !== vt[i]) begin errors++; $display("FAIL mul_mac_tag[%0d] got=%h want=%h", i, t, vt[i]); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL mul_mac_latency[%0d] got=%0d want=4", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          rcv = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_s = 16'd0;
    logic [7:0]  prev_t = 8'd0;
    // a = -(1+k), b = -1, so beat k yields k+1
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      if (sent < 10) begin
        in_valid = 1'b1; A_in = 16'd65520 - 16'(sent); B_in = 16'd65520; C_in = 16'd0;
        N_in = N1; Mu_in = MU1; mode_in = 1'b0; tag_in = 8'hA0 + 8'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || S_out !== prev_s || tag_out !== prev_t) begin
          errors++;
          $display("FAIL bp_stable cyc=%0d got v=%b S=%0d tag=%h want v=1 S=%0d tag=%h",
                   cyc, out_valid, S_out, tag_out, prev_s, prev_t);
        end
      end
      if (!out_ready && out_valid) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
      end
      stall_prev = out_valid && !out_ready;
      prev_s = S_out; prev_t = tag_out;
      if (out_valid && out_ready) begin
        checks++;
        if (rcv >= 10) begin
          errors++; $display("FAIL bp_extra got result #%0d want only 10", rcv);
        end else if (S_out !== 16'(rcv + 1) || tag_out !== 8'hA0 + 8'(rcv)) begin
          errors++;
          $display("FAIL bp_result[%0d] got S=%0d tag=%h want S=%0d tag=%h",
                   rcv, S_out, tag_out, rcv + 1, 8'hA0 + 8'(rcv));
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcv !== 10) begin errors++; $display("FAIL bp_count got=%0d want=10", rcv); end
  endtask

  task automatic test_mixed_moduli();
    logic [15:0] got_s [2];
    logic [7:0]  got_t [2];
    int          n = 0;
    out_ready = 1'b1; mode_in = 1'b0; C_in = 16'd0; A_in = 16'd300; B_in = 16'd300;
    in_valid = 1'b1; N_in = N1; Mu_in = MU1; tag_in = 8'h01;
    @(posedge clk); #1;
    N_in = 16'd65519; Mu_in = 17'd65553; tag_in = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      if (out_valid) begin got_s[n] = S_out; got_t[n] = tag_out; n++; end
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL mixed_count got=%0d want=2", n);
    end else begin
      // 90000 - 65521 and 90000 - 65519
      checks++; if (got_s[0] !== 16'd24479 || got_t[0] !== 8'h01) begin errors++; $display("FAIL mixed_beat1 got S=%0d tag=%h want S=24479 tag=01", got_s[0], got_t[0]); end
      checks++; if (got_s[1] !== 16'd24481 || got_t[1] !== 8'h02) begin errors++; $display("FAIL mixed_beat2 got S=%0d tag=%h want S=24481 tag=02", got_s[1], got_t[1]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] s;
    logic [7:0]  t;
    int          lat;
    logic        stale = 1'b0;
    out_ready = 1'b1; mode_in = 1'b0; C_in = 16'd0; N_in = N1; Mu_in = MU1; B_in = 16'd65520;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A_in = 16'd65520 - 16'(i); tag_in = 8'hE0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (S_out !== 16'd0 || tag_out !== 8'd0) begin errors++; $display("FAIL midrst_outputs got S=%0d tag=%h want S=0 tag=00", S_out, tag_out); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale got out_valid=1 want none"); end
    do_beat(16'd12345, 16'd3, 16'd0, N1, MU1, 1'b0, 8'h77, s, t, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got=%0d want=4", lat); end
    checks++; if (s !== 16'd37035 || t !== 8'h77) begin errors++; $display("FAIL midrst_result got S=%0d tag=%h want S=37035 tag=77", s, t); end
  endtask

  task automatic test_w64_stream();
    localparam int NB = 2000;
    logic [63:0]  n = 64'hFFFF_FFFF_0000_0001;
    logic [128:0] num;
    logic [129:0] full;
    logic [63:0]  exp_q [$];
    logic [7:0]   tag_q [$];
    logic [63:0]  pend_e;
    logic [63:0]  e;
    logic [7:0]   et;
    logic         have = 1'b0;
    int           sent = 0;
    int           rcv = 0;
    num  = 129'd1 << 128;
    n64  = n;
    mu64 = 65'(num / {65'd0, n});
    pend_e = 64'd0;
    for (int cyc = 0; cyc < 20000 && rcv < NB; cyc++) begin
      out_ready64 = ($urandom_range(0, 3) != 0);
      if (!have && sent < NB) begin
        if (sent == 0) begin
          // (N-1)^2 = (-1)^2 = 1
          a64 = n - 64'd1; b64 = n - 64'd1; c64 = 64'd0; mode64 = 1'b0; pend_e = 64'd1;
        end else begin
          a64 = {$urandom(), $urandom()} % n;
          b64 = {$urandom(), $urandom()} % n;
          c64 = {$urandom(), $urandom()} % n;
          mode64 = $urandom_range(0, 1) == 1;
          full = {66'd0, a64} * {66'd0, b64};
          if (mode64) full = full + {66'd0, c64};
          pend_e = 64'(full % {66'd0, n});
        end
        tag64 = 8'(sent);
        have = 1'b1;
      end
      in_valid64 = have && ($urandom_range(0, 7) != 0);
      #1;
      if (out_valid64 && out_ready64) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL w64_extra got S=%h with no beat outstanding", s64);
        end else begin
          e = exp_q.pop_front(); et = tag_q.pop_front();
          if (s64 !== e || tag_out64 !== et) begin
            errors++;
            $display("FAIL w64_result[%0d] got S=%h tag=%h want S=%h tag=%h", rcv, s64, tag_out64, e, et);
          end
        end
        rcv++;
      end
      if (in_valid64 && in_ready64) begin
        exp_q.push_back(pend_e); tag_q.push_back(tag64);
        sent++; have = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0; out_ready64 = 1'b1;
    checks++; if (rcv !== NB) begin errors++; $display("FAIL w64_count got=%0d want=%0d", rcv, NB); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode_in = 1'b0;
    A_in = 16'd0; B_in = 16'd0; C_in = 16'd0; N_in = N1; Mu_in = MU1; tag_in = 8'd0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; mode64 = 1'b0;
    a64 = 64'd0; b64 = 64'd0; c64 = 64'd0; n64 = 64'd0; mu64 = 65'd0; tag64 = 8'd0;
    test_reset();
    test_mul_mac();
    test_back_to_back();
    test_mixed_moduli();
    test_reset_midstream();
    test_w64_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
